ysyx_22040386_lsu: RTL and testbench

Load/store unit sitting between the execute stage and write-back: it consumes the execute stage's memory-request bundle (effective address, store data, access mask, read/write strobes, write-back info) and drives a single-outstanding valid/ready data-memory bus. It performs byte-lane alignment and strobe generation for stores, extraction and sign/zero extension for loads, and hands a finished write-back bundle downstream. Non-memory instructions pass through with one cycle of latency.

---
 rtl/ysyx_22040386_lsu.sv | 197 +++++++++++++++++++
 tb/tb_ysyx_22040386_lsu.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040386_lsu.sv
// Load/store unit: accepts one execute-stage request at a time, runs it over a valid/ready data bus
// with store lane alignment and load extension. Define YSYX_22040386_LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module ysyx_22040386_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [2:0]  in_mask,
    input  logic        in_memread,
    input  logic        in_memwrite,
    input  logic [4:0]  in_reg_wr_addr,
    input  logic        in_regwrite,
    input  logic [63:0] in_reg_wr_data,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [63:0] req_addr,
    output logic        req_wen,
    output logic [63:0] req_wdata,
    output logic [7:0]  req_wstrb,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [63:0] resp_rdata,
    input  logic        resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_reg_wr_addr,
    output logic        out_regwrite,
    output logic [63:0] out_reg_wr_data,
    output logic        out_err,
    output logic        out_misalign
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [2:0]  mask_q, mask_d;
    logic        store_q, store_d;
    logic [4:0]  rd_q, rd_d;
    logic        regwrite_q, regwrite_d;
    logic [63:0] reg_data_q, reg_data_d;
    logic [63:0] result_q, result_d;
    logic        out_regwrite_q, out_regwrite_d;
    logic        err_q, err_d;
    logic        misalign_q, misalign_d;

    logic [2:0]  off;
    logic [7:0]  size_strb;
    logic [63:0] shifted;
    logic [63:0] load_val;
`ifdef YSYX_22040386_LSU_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    // Lane alignment works on the latched request; bytes shifted past lane 7 simply fall off.
    always_comb begin
        off = addr_q[2:0];
        case (mask_q[1:0])
            2'b00:   size_strb = 8'h01;
            2'b01:   size_strb = 8'h03;
            2'b10:   size_strb = 8'h0F;
            default: size_strb = 8'hFF;
        endcase
        shifted = resp_rdata >> {off, 3'b000};
        case (mask_q)
            3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  load_val = {56'd0, shifted[7:0]};
            3'b101:  load_val = {48'd0, shifted[15:0]};
            3'b110:  load_val = {32'd0, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

`ifdef YSYX_22040386_LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (in_mask[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = in_addr[0];
            2'b10:   misaligned = |in_addr[1:0];
            default: misaligned = |in_addr[2:0];
        endcase
    end
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        mask_d         = mask_q;
        store_d        = store_q;
        rd_d           = rd_q;
        regwrite_d     = regwrite_q;
        reg_data_d     = reg_data_q;
        result_d       = result_q;
        out_regwrite_d = out_regwrite_q;
        err_d          = err_q;
        misalign_d     = misalign_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d         = in_addr;
                    wdata_d        = in_wdata;
                    mask_d         = in_mask;
                    store_d        = in_memwrite;
                    rd_d           = in_reg_wr_addr;
                    regwrite_d     = in_regwrite;
                    reg_data_d     = in_reg_wr_data;
                    result_d       = in_reg_wr_data;
                    out_regwrite_d = in_regwrite;
                    err_d          = 1'b0;
                    misalign_d     = 1'b0;
                    if (in_memread || in_memwrite) begin
`ifdef YSYX_22040386_LSU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            misalign_d     = 1'b1;
                            out_regwrite_d = 1'b0;
                            state_d        = DONE;
                        end else begin
                            state_d = REQ;
                        end
`else
                        state_d = REQ;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (req_ready) state_d = RESP;
            end
            RESP: begin
                if (resp_valid) begin
                    result_d       = store_q ? reg_data_q : load_val;
                    out_regwrite_d = regwrite_q & ~resp_err;
                    err_d          = resp_err;
                    state_d        = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            mask_q         <= '0;
            store_q        <= 1'b0;
            rd_q           <= '0;
            regwrite_q     <= 1'b0;
            reg_data_q     <= '0;
            result_q       <= '0;
            out_regwrite_q <= 1'b0;
            err_q          <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            mask_q         <= mask_d;
            store_q        <= store_d;
            rd_q           <= rd_d;
            regwrite_q     <= regwrite_d;
            reg_data_q     <= reg_data_d;
            result_q       <= result_d;
            out_regwrite_q <= out_regwrite_d;
            err_q          <= err_d;
            misalign_q     <= misalign_d;
        end
    end

    // Handshake outputs decode the state flop directly, so an async reset drops them at once.
    assign in_ready        = (state_q == IDLE);
    assign req_valid       = (state_q == REQ);
    assign resp_ready      = (state_q == RESP);
    assign out_valid       = (state_q == DONE);
    assign req_addr        = {addr_q[63:3], 3'b000};
    assign req_wen         = store_q;
    assign req_wdata       = wdata_q << {off, 3'b000};
    assign req_wstrb       = store_q ? (size_strb << off) : 8'h00;
    assign out_reg_wr_addr = rd_q;
    assign out_regwrite    = out_regwrite_q;
    assign out_reg_wr_data = result_q;
    assign out_err         = err_q;
    assign out_misalign    = misalign_q;

endmodule

// File: tb/tb_ysyx_22040386_lsu.sv
// Self-checking bench for ysyx_22040386_lsu: a byte-level model predicts bus and write-back values,
// a per-cycle compare process checks them, and directed vectors pin hand-computed results.
module tb_ysyx_22040386_lsu;

`ifdef YSYX_22040386_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] in_addr, in_wdata, in_reg_wr_data;
    logic [2:0]  in_mask;
    logic        in_memread, in_memwrite, in_regwrite;
    logic [4:0]  in_reg_wr_addr;
    logic        req_valid, req_ready, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        out_valid, out_ready, out_regwrite, out_err, out_misalign;
    logic [4:0]  out_reg_wr_addr;
    logic [63:0] out_reg_wr_data;

    int n_cmp = 0;
    int n_fail = 0;
    int hs_count = 0;
    bit chk_en = 1'b0;

    logic        exp_no_bus, exp_wen, exp_err, exp_misalign, exp_regwrite, exp_data_chk;
    logic [63:0] exp_req_addr, exp_wdata, exp_data;
    logic [7:0]  exp_wstrb;
    logic [4:0]  exp_rd;

    logic        snap_req_seen, snap_req_wen, snap_out_err, snap_out_regwrite, snap_out_misalign;
    logic [63:0] snap_req_addr, snap_req_wdata, snap_out_data;
    logic [7:0]  snap_req_wstrb;
    logic [4:0]  snap_rd;
    logic [7:0]  lane_byte;

    always #5 clk = ~clk;

    ysyx_22040386_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_mask(in_mask),
        .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_reg_wr_addr(in_reg_wr_addr), .in_regwrite(in_regwrite), .in_reg_wr_data(in_reg_wr_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_wr_addr(out_reg_wr_addr), .out_regwrite(out_regwrite),
        .out_reg_wr_data(out_reg_wr_data), .out_err(out_err), .out_misalign(out_misalign)
    );

    function automatic int nbytes(input logic [2:0] m);
        case (m[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [7:0] m_wstrb(input logic [63:0] addr, input logic [2:0] m);
        logic [7:0] s;
        int off;
        s = '0;
        off = int'(addr[2:0]);
        for (int i = 0; i < nbytes(m); i++)
            if (off + i < 8) s[off + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [63:0] addr);
        logic [63:0] d;
        int off;
        d = '0;
        off = int'(addr[2:0]);
        for (int j = off; j < 8; j++) d[8*j +: 8] = wd[8*(j-off) +: 8];
        return d;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [63:0] addr,
                                           input logic [2:0] m);
        logic [63:0] v;
        int off, n;
        v = '0;
        off = int'(addr[2:0]);
        n = nbytes(m);
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!m[2])
            for (int k = 8*n; k < 64; k++) v[k] = v[8*n-1];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle a bus request or a result is on offer, hold it against the model's prediction.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (req_valid) begin
                snap_req_seen  = 1'b1;
                snap_req_addr  = req_addr;
                snap_req_wen   = req_wen;
                snap_req_wdata = req_wdata;
                snap_req_wstrb = req_wstrb;
                checkOutput("req_unexpected", exp_no_bus, 1'b0);
                checkOutput("req_addr", req_addr, exp_req_addr);
                checkOutput("req_wen", req_wen, exp_wen);
                if (exp_wen) begin
                    checkOutput("req_wstrb", req_wstrb, exp_wstrb);
                    checkOutput("req_wdata", req_wdata, exp_wdata);
                end
            end
            if (out_valid) begin
                snap_out_data     = out_reg_wr_data;
                snap_out_err      = out_err;
                snap_out_regwrite = out_regwrite;
                snap_out_misalign = out_misalign;
                snap_rd           = out_reg_wr_addr;
                checkOutput("out_rd", out_reg_wr_addr, exp_rd);
                checkOutput("out_regwrite", out_regwrite, exp_regwrite);
                checkOutput("out_err", out_err, exp_err);
                checkOutput("out_misalign", out_misalign, exp_misalign);
                if (exp_data_chk) checkOutput("out_data", out_reg_wr_data, exp_data);
                if (out_ready) hs_count++;
            end
        end
    end

    // Drives one instruction, plays the bus with the requested stall/delay, then retires it.
    task automatic applyStimulus(input logic [63:0] addr, input logic [63:0] wdata, input logic [2:0] mask,
                                 input logic rd_en, input logic wr_en, input logic [4:0] rd,
                                 input logic rw, input logic [63:0] rwdata,
                                 input int stall, input int rdly, input logic [63:0] rdata, input logic err);
        int cyc, st, rl, exp_lat;
        logic is_mem, mis;
        is_mem       = rd_en | wr_en;
        mis          = is_mem && ((addr % 64'(nbytes(mask))) != 64'd0);
        exp_no_bus   = !is_mem || (mis && TRAP);
        exp_req_addr = addr & ~64'h7;
        exp_wen      = wr_en;
        exp_wstrb    = m_wstrb(addr, mask);
        exp_wdata    = m_wdata(wdata, addr);
        exp_err      = !exp_no_bus && err;
        exp_misalign = mis && TRAP;
        exp_regwrite = (exp_misalign || exp_err) ? 1'b0 : rw;
        exp_data_chk = !(exp_misalign || exp_err);
        exp_data     = (!is_mem || wr_en) ? rwdata : m_load(rdata, addr, mask);
        exp_rd       = rd;
        exp_lat      = exp_no_bus ? 0 : 2 + stall + rdly;
        hs_count     = 0;
        snap_req_seen = 1'b0;

        checkOutput("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_mask = mask;
        in_memread = rd_en; in_memwrite = wr_en; in_reg_wr_addr = rd;
        in_regwrite = rw; in_reg_wr_data = rwdata;
        @(posedge clk); #1;
        in_valid = 1'b0;

        cyc = 0; st = stall; rl = rdly;
        while (!out_valid && cyc < 64) begin
            req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0; resp_rdata = '0;
            if (req_valid) begin
                if (st > 0) st--;
                else req_ready = 1'b1;
            end
            if (resp_ready) begin
                if (rl > 0) rl--;
                else begin
                    resp_valid = 1'b1; resp_rdata = rdata; resp_err = err;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_ready = 1'b0; resp_valid = 1'b0; resp_err = 1'b0; resp_rdata = '0;
        checkOutput("latency", 64'(cyc), 64'(exp_lat));

        @(posedge clk); #1;
        checkOutput("hold_out_valid", out_valid, 1'b1);
        checkOutput("hold_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("retire_out_valid", out_valid, 1'b0);
        checkOutput("retire_in_ready", in_ready, 1'b1);
        checkOutput("handshakes", 64'(hs_count), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Directed sequence: reset state, each access flavour, stalls, faults, misalignment, reset mid-flight.
    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_addr = 0; in_wdata = 0; in_mask = 0; in_memread = 0; in_memwrite = 0;
        in_reg_wr_addr = 0; in_regwrite = 0; in_reg_wr_data = 0;
        req_ready = 0; resp_valid = 0; resp_rdata = 0; resp_err = 0; out_ready = 0;
        #2;
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_req_valid", req_valid, 1'b0);
        checkOutput("rst_resp_ready", resp_ready, 1'b0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_regwrite", out_regwrite, 1'b0);
        checkOutput("rst_out_err", out_err, 1'b0);
        checkOutput("rst_out_misalign", out_misalign, 1'b0);
        checkOutput("rst_req_addr", req_addr, 64'd0);
        checkOutput("rst_req_wdata", req_wdata, 64'd0);
        checkOutput("rst_req_wstrb", req_wstrb, 8'd0);
        checkOutput("rst_out_data", out_reg_wr_data, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        $display("[TB] add passthrough");
        applyStimulus(64'd0, 64'd0, 3'b000, 0, 0, 5'd5, 1, 64'h1234, 0, 0, 64'd0, 0);
        checkOutput("add_data_lit", snap_out_data, 64'h1234);
        checkOutput("add_rd_lit", snap_rd, 5'd5);
        checkOutput("add_no_req_lit", snap_req_seen, 1'b0);

        $display("[TB] SB 0x80000003");
        applyStimulus(64'h8000_0003, 64'hAB, 3'b000, 0, 1, 5'd0, 0, 64'd0, 0, 0, 64'd0, 0);
        lane_byte = snap_req_wdata[31:24];
        checkOutput("sb_addr_lit", snap_req_addr, 64'h8000_0000);
        checkOutput("sb_wstrb_lit", snap_req_wstrb, 8'h08);
        checkOutput("sb_lane_lit", lane_byte, 8'hAB);
        checkOutput("sb_wen_lit", snap_req_wen, 1'b1);

        $display("[TB] LB / LBU 0x80000005");
        applyStimulus(64'h8000_0005, 64'd0, 3'b000, 1, 0, 5'd10, 1, 64'd0, 0, 0, 64'h0000_8000_0000_0000, 0);
        checkOutput("lb_lit", snap_out_data, 64'hFFFF_FFFF_FFFF_FF80);
        applyStimulus(64'h8000_0005, 64'd0, 3'b100, 1, 0, 5'd11, 1, 64'd0, 0, 0, 64'h0000_8000_0000_0000, 0);
        checkOutput("lbu_lit", snap_out_data, 64'h80);

        $display("[TB] LW with bus stalls");
        applyStimulus(64'h8000_0004, 64'd0, 3'b010, 1, 0, 5'd12, 1, 64'd0, 3, 2, 64'h89AB_CDEF_0123_4567, 0);
        checkOutput("lw_lit", snap_out_data, 64'hFFFF_FFFF_89AB_CDEF);

        $display("[TB] LD with access fault, then clear");
        applyStimulus(64'h8000_0008, 64'd0, 3'b011, 1, 0, 5'd13, 1, 64'd0, 0, 1, 64'h1, 1);
        checkOutput("ld_err_lit", snap_out_err, 1'b1);
        checkOutput("ld_err_regwrite_lit", snap_out_regwrite, 1'b0);
        applyStimulus(64'd0, 64'd0, 3'b000, 0, 0, 5'd14, 1, 64'h77, 0, 0, 64'd0, 0);
        checkOutput("err_cleared_lit", snap_out_err, 1'b0);

        $display("[TB] assorted stores and loads");
        applyStimulus(64'h8000_0006, 64'h1122_3344_5566_7788, 3'b001, 0, 1, 5'd3, 1, 64'h55, 1, 0, 64'd0, 0);
        checkOutput("sh_wstrb_lit", snap_req_wstrb, 8'hC0);
        checkOutput("sh_wdata_lit", snap_req_wdata, 64'h7788_0000_0000_0000);
        applyStimulus(64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 3'b011, 0, 1, 5'd4, 0, 64'd0, 2, 1, 64'd0, 0);
        applyStimulus(64'h8000_0004, 64'd0, 3'b110, 1, 0, 5'd6, 1, 64'd0, 0, 0, 64'h89AB_CDEF_0123_4567, 0);
        checkOutput("lwu_lit", snap_out_data, 64'h89AB_CDEF);
        applyStimulus(64'h8000_0002, 64'd0, 3'b101, 1, 0, 5'd7, 1, 64'd0, 0, 1, 64'h0000_0000_F00D_0000, 0);
        applyStimulus(64'h8000_0000, 64'h0102_0304, 3'b010, 1, 1, 5'd8, 1, 64'h99, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        checkOutput("rw_store_lit", snap_out_data, 64'h99);
        applyStimulus(64'h8000_0018, 64'd0, 3'b111, 1, 0, 5'd9, 1, 64'd0, 0, 0, 64'h8123_4567_89AB_CDEF, 0);

        $display("[TB] misaligned LH 0x80000001");
        applyStimulus(64'h8000_0001, 64'd0, 3'b001, 1, 0, 5'd15, 1, 64'd0, 0, 0, 64'h1122_3344_55AB_CD66, 0);
`ifdef YSYX_22040386_LSU_MISALIGN_TRAP_EN
        checkOutput("lh_trap_lit", snap_out_misalign, 1'b1);
        checkOutput("lh_trap_no_req_lit", snap_req_seen, 1'b0);
`else
        checkOutput("lh_misalign_lit", snap_out_data, 64'hFFFF_FFFF_FFFF_ABCD);
        applyStimulus(64'h8000_0006, 64'd0, 3'b010, 1, 0, 5'd16, 1, 64'd0, 0, 0, 64'hBEEF_0000_0000_0000, 0);
        checkOutput("lw_cross_lit", snap_out_data, 64'hBEEF);
        applyStimulus(64'h8000_0006, 64'h1234_5678, 3'b010, 0, 1, 5'd17, 0, 64'd0, 0, 0, 64'd0, 0);
        checkOutput("sw_cross_wstrb_lit", snap_req_wstrb, 8'hC0);
`endif

        $display("[TB] reset during REQ");
        chk_en = 1'b0;
        in_valid = 1'b1; in_addr = 64'h8000_0020; in_mask = 3'b010; in_memread = 1'b1; in_memwrite = 1'b0;
        in_reg_wr_addr = 5'd2; in_regwrite = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_memread = 1'b0;
        checkOutput("pre_rst_req_valid", req_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        resp_valid = 1'b1; resp_rdata = 64'hFFFF; 
        #1;
        checkOutput("rst_req_drop", req_valid, 1'b0);
        checkOutput("rst_in_ready_mid", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_valid = 1'b0; resp_rdata = '0;
        @(posedge clk); #1;
        checkOutput("post_rst_out_valid", out_valid, 1'b0);
        checkOutput("post_rst_in_ready", in_ready, 1'b1);
        chk_en = 1'b1;

        applyStimulus(64'd0, 64'd0, 3'b000, 0, 0, 5'd31, 1, 64'hFEED, 0, 0, 64'd0, 0);
        checkOutput("after_rst_lit", snap_out_data, 64'hFEED);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
